// File: rtl/axi_lite_slave_ctrl.sv
// axi_lite_slave_ctrl: AXI4-Lite slave that turns each write/read into a one-cycle register-file WEN/REN pulse; ports: clk, reset (async, active-high), aw/w/b/ar/r AXI4-Lite channels, mem_* register-file write/read ports
module axi_lite_slave_ctrl #(
  parameter int addr_width = 6,
  parameter int data_width = 32,
  parameter int strb_width = data_width / 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [addr_width-1:0] awaddr,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [data_width-1:0] wdata,
  input  logic [strb_width-1:0] wstrb,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready,
  input  logic [addr_width-1:0] araddr,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [data_width-1:0] rdata,
  output logic [1:0]            rresp,
  output logic                  rvalid,
  input  logic                  rready,
  output logic                  mem_wen,
  output logic [addr_width-1:0] mem_awaddr,
  output logic [strb_width-1:0] mem_wstrb,
  output logic [data_width-1:0] mem_wdata,
  output logic                  mem_ren,
  output logic [addr_width-1:0] mem_araddr,
  input  logic [data_width-1:0] mem_rdata
);
  localparam logic [1:0] okay = 2'b00;
  localparam logic [1:0] slverr = 2'b10;
  typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_WAIT, R_RESP} r_state_t;
  w_state_t w_state, w_state_d;
  r_state_t r_state, r_state_d;
  logic aw_held, w_held, aw_held_d, w_held_d;
  logic [addr_width-1:0] aw_q, ar_q, w_addr, ar_addr;
  logic [data_width-1:0] wd_q, w_data;
  logic [strb_width-1:0] ws_q, w_strb;
  logic aw_hs, w_hs, ar_hs;
  logic awready_d, wready_d, bvalid_d, arready_d, rvalid_d;
  logic mem_wen_d, mem_ren_d, rdata_ld, rdata_clr;
  logic [1:0] bresp_d, rresp_d;
  assign aw_hs = awvalid && awready;
  assign w_hs = wvalid && wready;
  assign ar_hs = arvalid && arready;
  assign w_addr = aw_hs ? awaddr : aw_q;
  assign w_data = w_hs ? wdata : wd_q;
  assign w_strb = w_hs ? wstrb : ws_q;
  assign ar_addr = ar_hs ? araddr : ar_q;
  always_comb begin
    w_state_d = w_state;
    aw_held_d = aw_held;
    w_held_d = w_held;
    awready_d = awready;
    wready_d = wready;
    bvalid_d = bvalid;
    bresp_d = bresp;
    mem_wen_d = 1'b0;
    case (w_state)
      W_IDLE: begin
        aw_held_d = aw_held || aw_hs;
        w_held_d = w_held || w_hs;
        awready_d = !aw_held_d;
        wready_d = !w_held_d;
        if (aw_held_d && w_held_d) begin
          aw_held_d = 1'b0;
          w_held_d = 1'b0;
          w_state_d = (|w_addr[1:0]) ? W_RESP : W_EXEC;
          mem_wen_d = ~|w_addr[1:0];
          bresp_d = (|w_addr[1:0]) ? slverr : okay;
        end
      end
      W_EXEC: w_state_d = W_RESP;
      W_RESP: begin
        bvalid_d = !(bvalid && bready);
        if (bvalid && bready) begin
          w_state_d = W_IDLE;
          awready_d = 1'b1;
          wready_d = 1'b1;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end
  // the write pulse has priority: a read issue that would coincide with it waits one cycle
  always_comb begin
    r_state_d = r_state;
    arready_d = arready;
    rvalid_d = rvalid;
    rresp_d = rresp;
    mem_ren_d = 1'b0;
    rdata_ld = 1'b0;
    rdata_clr = 1'b0;
    case (r_state)
      R_IDLE: begin
        arready_d = !ar_hs;
        if (ar_hs) begin
          r_state_d = (|araddr[1:0]) ? R_RESP : R_ISSUE;
          rresp_d = (|araddr[1:0]) ? slverr : okay;
          rdata_clr = |araddr[1:0];
          mem_ren_d = ~|araddr[1:0] && !mem_wen_d;
        end
      end
      R_ISSUE: begin
        r_state_d = mem_ren ? R_WAIT : R_ISSUE;
        mem_ren_d = !mem_ren && !mem_wen_d;
      end
      R_WAIT: begin
        r_state_d = R_RESP;
        rvalid_d = 1'b1;
        rdata_ld = 1'b1;
      end
      R_RESP: begin
        rvalid_d = !(rvalid && rready);
        if (rvalid && rready) begin
          r_state_d = R_IDLE;
          arready_d = 1'b1;
        end
      end
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
      aw_held <= 1'b0;
      w_held <= 1'b0;
      aw_q <= '0;
      wd_q <= '0;
      ws_q <= '0;
      ar_q <= '0;
      awready <= 1'b0;
      wready <= 1'b0;
      bvalid <= 1'b0;
      bresp <= '0;
      arready <= 1'b0;
      rvalid <= 1'b0;
      rresp <= '0;
      rdata <= '0;
      mem_wen <= 1'b0;
      mem_awaddr <= '0;
      mem_wstrb <= '0;
      mem_wdata <= '0;
      mem_ren <= 1'b0;
      mem_araddr <= '0;
    end else begin
      w_state <= w_state_d;
      r_state <= r_state_d;
      aw_held <= aw_held_d;
      w_held <= w_held_d;
      aw_q <= w_addr;
      wd_q <= w_data;
      ws_q <= w_strb;
      ar_q <= ar_addr;
      awready <= awready_d;
      wready <= wready_d;
      bvalid <= bvalid_d;
      bresp <= bresp_d;
      arready <= arready_d;
      rvalid <= rvalid_d;
      rresp <= rresp_d;
      rdata <= rdata_ld ? mem_rdata : rdata_clr ? '0 : rdata;
      mem_wen <= mem_wen_d;
      mem_awaddr <= mem_wen_d ? w_addr : mem_awaddr;
      mem_wstrb <= mem_wen_d ? w_strb : mem_wstrb;
      mem_wdata <= mem_wen_d ? w_data : mem_wdata;
      mem_ren <= mem_ren_d;
      mem_araddr <= mem_ren_d ? ar_addr : mem_araddr;
    end
  end
endmodule

// File: tb/tb_axi_lite_slave_ctrl.sv
// tb_axi_lite_slave_ctrl: randomized self-checking bench for axi_lite_slave_ctrl with a behavioural register file and reference memory
module tb_axi_lite_slave_ctrl;
  logic clk = 1'b0;
  logic reset;
  logic [5:0] awaddr, araddr, mem_awaddr, mem_araddr;
  logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata, mem_wdata, mem_rdata;
  logic [3:0] wstrb, mem_wstrb;
  logic [1:0] bresp, rresp;
  logic mem_wen, mem_ren, mem_init;
  logic [31:0] env_mem [16];
  logic [31:0] ref_mem [16];
  logic [90:0] outs;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  axi_lite_slave_ctrl dut (
    .clk(clk), .reset(reset),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .mem_wen(mem_wen), .mem_awaddr(mem_awaddr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_ren(mem_ren), .mem_araddr(mem_araddr), .mem_rdata(mem_rdata)
  );
  assign outs = {awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid,
                 mem_wen, mem_awaddr, mem_wstrb, mem_wdata, mem_ren, mem_araddr};
  function automatic logic [31:0] init_word(input int i);
    return 32'hC3A50F00 ^ (32'(i) * 32'h01010101);
  endfunction
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nd, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = nd[8*b +: 8];
    return r;
  endfunction
  always @(posedge clk) begin
    if (mem_init) for (int i = 0; i < 16; i++) env_mem[i] <= init_word(i);
    else if (mem_wen) env_mem[mem_awaddr[5:2]] <= merge(env_mem[mem_awaddr[5:2]], mem_wdata, mem_wstrb);
    if (mem_ren) mem_rdata <= env_mem[mem_araddr[5:2]];
  end
  always @(negedge clk) if (!reset) begin
    checks++;
    if (mem_wen && mem_ren) begin
      failures++;
      $display("FAIL wen_ren_overlap t=%0t mem_wen=%b mem_ren=%b required not both 1", $time, mem_wen, mem_ren);
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle_inputs();
    awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
    araddr = '0; arvalid = 0; rready = 0;
  endtask
  task automatic test_reset();
    idle_inputs();
    reset = 1; mem_init = 1;
    for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
    step(); step();
    checks++;
    if (outs !== '0) begin failures++; $display("FAIL reset_outs got=%h required=0", outs); end
    mem_init = 0; reset = 0;
    checks++;
    if ({awready, wready, arready} !== 3'b000) begin failures++; $display("FAIL reset_ready_early got=%b required=000", {awready, wready, arready}); end
    step();
    checks++;
    if ({awready, wready, arready} !== 3'b111) begin failures++; $display("FAIL reset_ready got=%b required=111", {awready, wready, arready}); end
  endtask
  task automatic test_write_together();
    awaddr = 12; awvalid = 1; wdata = 32'hAA00CCC3; wstrb = 4'b1011; wvalid = 1;
    step();
    awvalid = 0; wvalid = 0;
    ref_mem[3] = merge(ref_mem[3], 32'hAA00CCC3, 4'b1011);
    checks++;
    if (mem_wen !== 1 || mem_awaddr !== 12 || mem_wdata !== 32'hAA00CCC3 || mem_wstrb !== 4'b1011) begin
      failures++; $display("FAIL wt_pulse got wen=%b a=%0d d=%h s=%b required 1 12 aa00ccc3 1011", mem_wen, mem_awaddr, mem_wdata, mem_wstrb);
    end
    checks++;
    if (awready !== 0 || wready !== 0) begin failures++; $display("FAIL wt_ready_drop got aw=%b w=%b required 0 0", awready, wready); end
    step();
    checks++;
    if (mem_wen !== 0 || bvalid !== 0) begin failures++; $display("FAIL wt_e1 got wen=%b bvalid=%b required 0 0", mem_wen, bvalid); end
    step();
    checks++;
    if (bvalid !== 1 || bresp !== 2'b00) begin failures++; $display("FAIL wt_bresp got bvalid=%b bresp=%b required 1 00", bvalid, bresp); end
    bready = 1; step(); bready = 0;
    checks++;
    if (bvalid !== 0 || awready !== 1 || wready !== 1) begin failures++; $display("FAIL wt_done got bvalid=%b aw=%b w=%b required 0 1 1", bvalid, awready, wready); end
  endtask
  task automatic test_w_before_aw();
    wdata = 32'h11223344; wstrb = 4'b1011; wvalid = 1;
    step();
    wvalid = 0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (mem_wen !== 0 || wready !== 0) begin failures++; $display("FAIL wb_early got wen=%b wready=%b required 0 0", mem_wen, wready); end
      step();
    end
    awaddr = 12; awvalid = 1;
    checks++;
    if (mem_wen !== 0) begin failures++; $display("FAIL wb_before_aw got wen=%b required 0", mem_wen); end
    step();
    awvalid = 0;
    ref_mem[3] = merge(ref_mem[3], 32'h11223344, 4'b1011);
    checks++;
    if (mem_wen !== 1 || mem_wdata !== 32'h11223344 || mem_awaddr !== 12) begin
      failures++; $display("FAIL wb_pulse got wen=%b d=%h a=%0d required 1 11223344 12", mem_wen, mem_wdata, mem_awaddr);
    end
    step(); step();
    checks++;
    if (bvalid !== 1 || bresp !== 2'b00) begin failures++; $display("FAIL wb_bresp got %b %b required 1 00", bvalid, bresp); end
    bready = 1; step(); bready = 0;
    araddr = 12; arvalid = 1;
    step();
    arvalid = 0;
    checks++;
    if (mem_ren !== 1 || mem_araddr !== 12 || arready !== 0) begin failures++; $display("FAIL rd_issue got ren=%b a=%0d arready=%b required 1 12 0", mem_ren, mem_araddr, arready); end
    step();
    checks++;
    if (rvalid !== 0) begin failures++; $display("FAIL rd_early got rvalid=%b required 0", rvalid); end
    step();
    checks++;
    if (rvalid !== 1 || rdata !== ref_mem[3] || rresp !== 2'b00) begin
      failures++; $display("FAIL rd_data got v=%b d=%h r=%b required 1 %h 00", rvalid, rdata, rresp, ref_mem[3]);
    end
    rready = 1; step(); rready = 0;
    checks++;
    if (rvalid !== 0 || arready !== 1) begin failures++; $display("FAIL rd_done got rvalid=%b arready=%b required 0 1", rvalid, arready); end
  endtask
  task automatic test_back_to_back_same_edge();
    logic [31:0] d;
    d = $urandom;
    awaddr = 8; awvalid = 1; wdata = d; wstrb = 4'b1111; wvalid = 1; araddr = 8; arvalid = 1;
    step();
    awvalid = 0; wvalid = 0; arvalid = 0;
    ref_mem[2] = d;
    checks++;
    if (mem_wen !== 1 || mem_ren !== 0) begin failures++; $display("FAIL se_e0 got wen=%b ren=%b required 1 0", mem_wen, mem_ren); end
    step();
    checks++;
    if (mem_wen !== 0 || mem_ren !== 1 || mem_araddr !== 8) begin failures++; $display("FAIL se_e1 got wen=%b ren=%b a=%0d required 0 1 8", mem_wen, mem_ren, mem_araddr); end
    step();
    checks++;
    if (bvalid !== 1 || rvalid !== 0) begin failures++; $display("FAIL se_e2 got bvalid=%b rvalid=%b required 1 0", bvalid, rvalid); end
    step();
    checks++;
    if (rvalid !== 1 || rdata !== d || rresp !== 2'b00) begin failures++; $display("FAIL se_rdata got v=%b d=%h r=%b required 1 %h 00", rvalid, rdata, rresp, d); end
    bready = 1; rready = 1; step(); bready = 0; rready = 0;
    checks++;
    if (bvalid !== 0 || rvalid !== 0 || awready !== 1 || arready !== 1) begin
      failures++; $display("FAIL se_done got b=%b r=%b aw=%b ar=%b required 0 0 1 1", bvalid, rvalid, awready, arready);
    end
  endtask
  task automatic test_backpressure();
    logic [31:0] d;
    logic [3:0] s;
    int n;
    d = $urandom; s = 4'($urandom);
    awaddr = 4; awvalid = 1; wdata = d; wstrb = s; wvalid = 1;
    step();
    awvalid = 0; wvalid = 0;
    ref_mem[1] = merge(ref_mem[1], d, s);
    n = 0;
    while (bvalid !== 1 && n < 8) begin step(); n++; end
    checks++;
    if (bvalid !== 1) begin failures++; $display("FAIL bp_b_timeout got bvalid=%b required 1", bvalid); end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (bvalid !== 1 || bresp !== 2'b00 || awready !== 0 || wready !== 0) begin
        failures++; $display("FAIL bp_b_hold c=%0d got v=%b r=%b aw=%b w=%b required 1 00 0 0", i, bvalid, bresp, awready, wready);
      end
    end
    bready = 1; step(); bready = 0;
    checks++;
    if (awready !== 1 || bvalid !== 0) begin failures++; $display("FAIL bp_b_release got aw=%b b=%b required 1 0", awready, bvalid); end
    araddr = 4; arvalid = 1;
    step();
    arvalid = 0;
    n = 0;
    while (rvalid !== 1 && n < 8) begin step(); n++; end
    checks++;
    if (rvalid !== 1) begin failures++; $display("FAIL bp_r_timeout got rvalid=%b required 1", rvalid); end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (rvalid !== 1 || rdata !== ref_mem[1] || rresp !== 2'b00 || arready !== 0) begin
        failures++; $display("FAIL bp_r_hold c=%0d got v=%b d=%h r=%b ar=%b required 1 %h 00 0", i, rvalid, rdata, rresp, arready, ref_mem[1]);
      end
    end
    rready = 1; step(); rready = 0;
    checks++;
    if (arready !== 1 || rvalid !== 0) begin failures++; $display("FAIL bp_r_release got ar=%b r=%b required 1 0", arready, rvalid); end
  endtask
  task automatic test_misaligned();
    int n;
    bit seen;
    awaddr = 13; awvalid = 1; wdata = $urandom; wstrb = 4'hF; wvalid = 1;
    step();
    awvalid = 0; wvalid = 0;
    seen = mem_wen; n = 0;
    while (bvalid !== 1 && n < 8) begin step(); n++; if (mem_wen === 1) seen = 1; end
    checks++;
    if (seen || bvalid !== 1 || bresp !== 2'b10) begin failures++; $display("FAIL mis_wr got wen_seen=%b v=%b r=%b required 0 1 10", seen, bvalid, bresp); end
    bready = 1; step(); bready = 0;
    araddr = 14; arvalid = 1;
    step();
    arvalid = 0;
    seen = mem_ren; n = 0;
    while (rvalid !== 1 && n < 8) begin step(); n++; if (mem_ren === 1) seen = 1; end
    checks++;
    if (seen || rvalid !== 1 || rresp !== 2'b10 || rdata !== 0) begin
      failures++; $display("FAIL mis_rd got ren_seen=%b v=%b r=%b d=%h required 0 1 10 0", seen, rvalid, rresp, rdata);
    end
    rready = 1; step(); rready = 0;
  endtask
  task automatic test_reset_mid();
    logic [31:0] d;
    d = $urandom;
    awaddr = 20; awvalid = 1; wdata = d; wstrb = 4'hF; wvalid = 1;
    step();
    awvalid = 0; wvalid = 0;
    ref_mem[5] = d;
    step(); step();
    checks++;
    if (bvalid !== 1) begin failures++; $display("FAIL rm_wresp got bvalid=%b required 1", bvalid); end
    #2 reset = 1;
    #1;
    checks++;
    if (outs !== '0) begin failures++; $display("FAIL rm_w_outs got=%h required=0", outs); end
    step();
    reset = 0;
    step();
    checks++;
    if ({awready, wready, arready} !== 3'b111) begin failures++; $display("FAIL rm_w_ready got=%b required 111", {awready, wready, arready}); end
    araddr = 20; arvalid = 1;
    step();
    arvalid = 0;
    step();
    #2 reset = 1;
    #1;
    checks++;
    if (outs !== '0) begin failures++; $display("FAIL rm_r_outs got=%h required=0", outs); end
    step();
    reset = 0;
    step();
    checks++;
    if ({awready, wready, arready} !== 3'b111) begin failures++; $display("FAIL rm_r_ready got=%b required 111", {awready, wready, arready}); end
    d = $urandom;
    awaddr = 24; awvalid = 1; wdata = d; wstrb = 4'hF; wvalid = 1;
    step();
    awvalid = 0; wvalid = 0;
    ref_mem[6] = d;
    checks++;
    if (mem_wen !== 1 || mem_wdata !== d) begin failures++; $display("FAIL rm_fresh_wen got %b %h required 1 %h", mem_wen, mem_wdata, d); end
    step(); step();
    checks++;
    if (bvalid !== 1 || bresp !== 2'b00) begin failures++; $display("FAIL rm_fresh_b got %b %b required 1 00", bvalid, bresp); end
    bready = 1; step(); bready = 0;
    for (int k = 5; k <= 6; k++) begin
      araddr = 6'(k * 4); arvalid = 1;
      step();
      arvalid = 0;
      step(); step();
      checks++;
      if (rvalid !== 1 || rdata !== ref_mem[k]) begin failures++; $display("FAIL rm_readback w=%0d got v=%b d=%h required 1 %h", k, rvalid, rdata, ref_mem[k]); end
      rready = 1; step(); rready = 0;
    end
  endtask
  task automatic test_random();
    for (int it = 0; it < 24; it++) begin
      logic [5:0] a;
      logic [31:0] d;
      logic [3:0] s;
      logic pa, pw;
      int awd, wd, n, lat;
      bit awdone, wdone, mis, seen;
      a = 6'($urandom_range(0, 15) * 4);
      if ($urandom_range(0, 3) == 0) a = a + 6'($urandom_range(1, 3));
      mis = (a[1:0] != 2'b00);
      d = $urandom; s = 4'($urandom);
      awd = $urandom_range(0, 3); wd = $urandom_range(0, 3);
      awaddr = a; wdata = d; wstrb = s;
      awdone = 0; wdone = 0; n = 0;
      while (!(awdone && wdone) && n < 20) begin
        awvalid = !awdone && n >= awd;
        wvalid = !wdone && n >= wd;
        pa = awvalid && awready;
        pw = wvalid && wready;
        step(); n++;
        if (pa) awdone = 1;
        if (pw) wdone = 1;
      end
      awvalid = 0; wvalid = 0;
      checks++;
      if (!(awdone && wdone) || mem_wen !== !mis) begin
        failures++; $display("FAIL rnd_wr_accept it=%0d a=%0d done=%b%b wen=%b required 11 %b", it, a, awdone, wdone, mem_wen, !mis);
      end
      if (!mis) begin
        ref_mem[a[5:2]] = merge(ref_mem[a[5:2]], d, s);
        checks++;
        if (mem_awaddr !== a || mem_wdata !== d || mem_wstrb !== s) begin
          failures++; $display("FAIL rnd_wr_port it=%0d got a=%0d d=%h s=%b required %0d %h %b", it, mem_awaddr, mem_wdata, mem_wstrb, a, d, s);
        end
      end
      seen = mis && mem_wen; lat = 0;
      while (bvalid !== 1 && lat < 10) begin step(); lat++; if (mis && mem_wen === 1) seen = 1; end
      checks++;
      if (bvalid !== 1 || bresp !== (mis ? 2'b10 : 2'b00) || (!mis && lat != 2) || seen) begin
        failures++; $display("FAIL rnd_wr_resp it=%0d a=%0d got v=%b r=%b lat=%0d wen_seen=%b required 1 %b lat=2 0", it, a, bvalid, bresp, lat, seen, mis ? 2'b10 : 2'b00);
      end
      repeat ($urandom_range(0, 3)) begin
        step();
        checks++;
        if (bvalid !== 1) begin failures++; $display("FAIL rnd_b_hold it=%0d got bvalid=%b required 1", it, bvalid); end
      end
      bready = 1; step(); bready = 0;
      checks++;
      if (bvalid !== 0) begin failures++; $display("FAIL rnd_b_drop it=%0d got bvalid=%b required 0", it, bvalid); end
      a = 6'($urandom_range(0, 15) * 4);
      if ($urandom_range(0, 3) == 0) a = a + 6'($urandom_range(1, 3));
      mis = (a[1:0] != 2'b00);
      araddr = a; arvalid = 1; awdone = 0; n = 0;
      while (!awdone && n < 10) begin
        pa = arvalid && arready;
        step(); n++;
        if (pa) awdone = 1;
      end
      arvalid = 0;
      checks++;
      if (!awdone || mem_ren !== !mis) begin failures++; $display("FAIL rnd_rd_accept it=%0d a=%0d done=%b ren=%b required 1 %b", it, a, awdone, mem_ren, !mis); end
      lat = 0;
      while (rvalid !== 1 && lat < 10) begin step(); lat++; end
      checks++;
      if (rvalid !== 1 || rresp !== (mis ? 2'b10 : 2'b00) || rdata !== (mis ? 32'h0 : ref_mem[a[5:2]]) || (!mis && lat != 2)) begin
        failures++; $display("FAIL rnd_rd_resp it=%0d a=%0d got v=%b r=%b d=%h lat=%0d required 1 %b %h lat=2", it, a, rvalid, rresp, rdata, lat, mis ? 2'b10 : 2'b00, mis ? 32'h0 : ref_mem[a[5:2]]);
      end
      repeat ($urandom_range(0, 3)) step();
      rready = 1; step(); rready = 0;
      checks++;
      if (rvalid !== 0 || arready !== 1) begin failures++; $display("FAIL rnd_r_done it=%0d got r=%b ar=%b required 0 1", it, rvalid, arready); end
    end
  endtask
  initial begin
    test_reset();
    test_write_together();
    test_w_before_aw();
    test_back_to_back_same_edge();
    test_backpressure();
    test_misaligned();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/axi_lite_slave_ctrl.md
# axi_lite_slave_ctrl

AXI4-Lite slave protocol controller that sits directly upstream of the byte-strobed register-file memory. It terminates the five AXI4-Lite channels and converts each accepted transaction into a single-cycle memory write pulse (WEN) or read pulse (REN), returning a response to the master. Write and read paths are independent FSMs. A fixed write-first arbiter makes read-after-write to the same address deterministic.

## Interface
- addrWidth, 6, byte address width (memory holds 2^(addrWidth-2) 32-bit words)
- dataWidth, 32, data width
- strbWidth, 4, byte strobes (dataWidth/8)

- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- AWADDR/AWVALID/AWREADY  in/in/out  addrWidth/1/1  write address channel
- WDATA/WSTRB/WVALID/WREADY  in/in/in/out  dataWidth/strbWidth/1/1  write data channel
- BRESP/BVALID/BREADY  out/out/in  2/1/1  write response channel
- ARADDR/ARVALID/ARREADY  in/in/out  addrWidth/1/1  read address channel
- RDATA/RRESP/RVALID/RREADY  out/out/out/in  dataWidth/2/1/1  read data channel
- MEM_WEN, MEM_AWADDR, MEM_WSTRB, MEM_WDATA  out  1/addrWidth/strbWidth/dataWidth  memory write port
- MEM_REN, MEM_ARADDR  out  1/addrWidth  memory read port
- MEM_RDATA  in  dataWidth  memory read data, registered by memory on the edge that samples MEM_REN high

## Operation
- All outputs registered. Reset value of every output is 0, and both FSMs go to IDLE. Pending transactions are dropped with no response.
- Write FSM states:
  - W_IDLE: AWREADY=1 until AW is captured; WREADY=1 until W is captured. AW and W may arrive in either order or together. When both are held → W_EXEC.
  - W_EXEC: drive MEM_WEN=1 for exactly one cycle with the latched address, strobe and data → W_RESP.
  - W_RESP: BVALID=1 and hold BRESP until BREADY is sampled high → W_IDLE.
- Read FSM states:
  - R_IDLE: ARREADY=1. An AR handshake latches the address → R_ISSUE.
  - R_ISSUE: MEM_REN=1 for one cycle → R_WAIT.
  - R_WAIT: capture MEM_RDATA into RDATA → R_RESP.
  - R_RESP: RVALID=1 and hold RDATA/RRESP until RREADY is sampled high → R_IDLE.
- Misaligned address (addr[1:0]≠0):
  - Write: no MEM_WEN pulse (W_EXEC skipped), BRESP=2'b10 SLVERR.
  - Read: no MEM_REN pulse, RDATA=0, RRESP=SLVERR.
- Aligned transactions return OKAY (2'b00).
- WSTRB=0 is legal: MEM_WEN still pulses, BRESP=OKAY.
- Arbitration: if W_EXEC and R_ISSUE would coincide, the write proceeds and R_ISSUE stalls one cycle (MEM_REN waits). A read issued in that situation therefore returns post-write data.
- MEM_* address/data outputs hold their last value when not strobed. MEM_WEN and MEM_REN are never high in the same cycle.
- No outstanding-transaction queue: one write and one read in flight at most.

## Timing
- Write, AW and W handshaken on the same edge E0: MEM_WEN high E0→E1; BVALID high from E2.
- Write, AW and W on different edges: latency counts from the later handshake.
- Read, AR on edge E0: MEM_REN high E0→E1; RVALID high from E2 (data valid with RVALID); add 1 cycle if stalled by a write.
- Ready deasserts the cycle after its handshake and reasserts the cycle after the B or R handshake. Minimum back-to-back spacing is 4 cycles for writes and 4 for reads.
- BVALID/RVALID never drop without the matching READY. The response payload is stable while VALID is high.
- Reset asserted mid-transaction: outputs are 0 immediately (asynchronous). READY signals go to 1 on the first clk edge after reset is released.

## Test plan
- Write 12, WDATA=0xAA00CCC3, WSTRB=4'b1011, AW and W together → one MEM_WEN pulse with the same address/data/strobe at E0+1; BVALID at E0+2, BRESP=00.
- W presented 3 cycles before AW, then read 12 → MEM_WEN only after AW; RDATA equals the memory contents with byte 2 unchanged, RRESP=00, RVALID at AR edge+2.
- Write 8 and read 8 with handshakes on the same edge → MEM_WEN precedes MEM_REN by one cycle; RDATA equals the new write data.
- BREADY/RREADY held low for 5 cycles → BVALID/RVALID and BRESP/RDATA stable for all 5; AWREADY/ARREADY remain 0 until the response handshakes.
- Write to 13, read from 14 → no MEM_WEN/MEM_REN pulse; BRESP=10; RRESP=10 with RDATA=0.
- Assert reset during W_RESP and during R_WAIT → all outputs 0 at once; after release, READY=1 on the next edge and a fresh write completes normally.
